// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM encoding, default
// expected words and the Avalon word addresses of the ID slave.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CMP   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h6B4AC772;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h4DFA7339;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Counter width able to hold the limit value itself; never below one bit.
  function automatic int ctr_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Stall counter for one Avalon read: counts stalled cycles and flags when the
// count sits at a nonzero limit. A zero limit never expires.
module sysid_timeout_ctr
  import sysid_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  assign expired = (limit != '0) && (count == limit);

  // Clear wins over enable; the count saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads the system ID and build timestamp words from an Avalon-MM slave and
// compares them against the expected values, with a per-read stall timeout.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [2:0]  dbg_state
);

  localparam int          CW    = ctr_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  state_t state, state_nx;
  logic   auto_pending;
  logic   go;
  logic   xfer_done;
  logic   stalled;
  logic   expired;
  logic   abort;
  logic   ctr_clear;

  // Handshake: a read is offered while avm_read=1 and completes on the edge
  // where avm_waitrequest=0; address and read hold unchanged until then.
  assign xfer_done = avm_read && !avm_waitrequest;
  assign stalled   = avm_read && avm_waitrequest;
  assign abort     = stalled && expired;
  assign go        = start || auto_pending;
  assign ctr_clear = xfer_done || (state_nx != state);
  assign dbg_state = state;

  sysid_timeout_ctr #(
    .W (CW)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear),
    .enable  (stalled),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    avm_read    = 1'b0;
    avm_address = ADDR_ID;
    busy        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) state_nx = ST_RD_ID;
      end
      ST_RD_ID: begin
        avm_read = 1'b1;
        busy     = 1'b1;
        if (!avm_waitrequest) state_nx = ST_RD_TS;
        else if (expired)     state_nx = ST_FIN;
      end
      ST_RD_TS: begin
        avm_read    = 1'b1;
        avm_address = ADDR_TS;
        busy        = 1'b1;
        if (!avm_waitrequest) state_nx = ST_CMP;
        else if (expired)     state_nx = ST_FIN;
      end
      ST_CMP: begin
        busy     = 1'b1;
        state_nx = ST_FIN;
      end
      ST_FIN: begin
        if (go) state_nx = ST_RD_ID;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Auto-start is a one-cycle pulse on the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_pending <= (AUTO_START != 0);
      done         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      timeout      <= 1'b0;
      id_value     <= '0;
      ts_value     <= '0;
    end else begin
      auto_pending <= 1'b0;
      if (state == ST_RD_ID && xfer_done) id_value <= avm_readdata;
      if (state == ST_RD_TS && xfer_done) ts_value <= avm_readdata;
      if (state == ST_CMP) begin
        id_ok <= (id_value == EXPECTED_ID);
        ts_ok <= (ts_value == EXPECTED_TS);
        done  <= 1'b1;
      end
      if (abort) begin
        timeout <= 1'b1;
        done    <= 1'b1;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
      end
      if (state == ST_FIN && go) begin
        done    <= 1'b0;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end
    end
  end

endmodule
